// File: rtl/alu_rs_pkg.sv
// ============================================================================
// Module  : alu_rs_pkg
// Purpose : Shared machine-word / tag / opcode defines plus the reservation
//           station entry type and snoop helper used by alu_rs.
// Contents: `WORD_T, `ADDR_T, `REGTAG_T, `REGADDR_T, `SINST_T, `UNLOCKED,
//           `ZERO, `OP_* encodings; rs_entry_t; snoop_hit().
// Revision: 1.0 - initial release
// ============================================================================
`ifndef ALU_RS_DEFINES
`define ALU_RS_DEFINES
`define WORD_T    logic [31:0]
`define ADDR_T    logic [31:0]
`define REGTAG_T  logic [3:0]
`define REGADDR_T logic [4:0]
`define SINST_T   logic [3:0]
`define UNLOCKED  4'h0
`define ZERO      32'h0000_0000
`define OP_NOP    4'h0
`define OP_ADD    4'h1
`define OP_SUB    4'h2
`define OP_AND    4'h3
`define OP_OR     4'h4
`define OP_XOR    4'h5
`endif

`default_nettype none

package alu_rs_pkg;

   // One reservation station slot.
   typedef struct packed {
      logic       valid;
      `SINST_T    op;
      `ADDR_T     pc;
      `REGTAG_T   tagx;
      `REGTAG_T   tagy;
      `WORD_T     datax;
      `WORD_T     datay;
      `REGADDR_T  target;
   } rs_entry_t;

   // An operand captures a broadcast only while it is still waiting on a
   // producer; an already-unlocked operand must never be overwritten even if
   // the broadcast tag happens to equal `UNLOCKED.
   function automatic logic snoop_hit(input `REGTAG_T tag,
                                      input logic     wb_en,
                                      input `REGTAG_T wb_tag);
      return wb_en && (tag == wb_tag) && (tag != `UNLOCKED);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs_picker.sv
// ============================================================================
// Module  : rs_picker
// Purpose : Lowest-index priority picker. Reports whether any request bit is
//           set and the encoded index of the lowest one.
// Ports   : req   [N-1:0]     - request vector
//           found             - at least one request bit set
//           idx   [IDX_W-1:0] - index of lowest set bit (0 when none)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_picker #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module  : alu_rs
// Purpose : ALU reservation station. Holds DEPTH dispatched instructions,
//           wakes operands from the writeback broadcast and issues the
//           lowest-index ready entry to the ALU once per cycle.
// Ports   : clk, rst_n (async, active low), rdy (global stall)
//           in_*      - dispatch interface, in_ready back-pressure
//           wb_*      - writeback snoop broadcast
//           flush     - jump redirect, kills every entry
//           alu_*_out - registered issue interface to the ALU
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rdy,

   input  logic       in_valid,
   input  `SINST_T    in_op,
   input  `ADDR_T     in_pc,
   input  `REGTAG_T   in_tagx,
   input  `REGTAG_T   in_tagy,
   input  `WORD_T     in_datax,
   input  `WORD_T     in_datay,
   input  `REGADDR_T  in_target,
   output logic       in_ready,

   input  logic       wb_en,
   input  `REGTAG_T   wb_tag,
   input  `WORD_T     wb_data,

   input  logic       flush,

   output logic       alu_busy_out,
   output `SINST_T    alu_op_out,
   output `ADDR_T     alu_pc_out,
   output `REGTAG_T   alu_tagx_out,
   output `REGTAG_T   alu_tagy_out,
   output `REGTAG_T   alu_tagw_out,
   output `WORD_T     alu_datax_out,
   output `WORD_T     alu_datay_out,
   output `REGADDR_T  alu_target_out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rs_entry_t        entries_q [DEPTH];
   rs_entry_t        entries_d [DEPTH];

   logic             busy_q,   busy_d;
   `SINST_T          op_q,     op_d;
   `ADDR_T           pc_q,     pc_d;
   `WORD_T           datax_q,  datax_d;
   `WORD_T           datay_q,  datay_d;
   `REGADDR_T        target_q, target_d;

   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] free_vec;
   logic             issue_found;
   logic [IDX_W-1:0] issue_idx;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   rs_entry_t        new_entry;

   // Readiness and freeness come from registered entry state only, so a
   // freshly allocated or woken entry waits one full cycle before issue and
   // a slot freed by issue is not offered to dispatch in the same cycle.
   for (genvar i = 0; i < DEPTH; i++) begin : g_status
      assign ready_vec[i] = entries_q[i].valid &&
                            (entries_q[i].tagx == `UNLOCKED) &&
                            (entries_q[i].tagy == `UNLOCKED);
      assign free_vec[i]  = !entries_q[i].valid;
   end

   rs_picker #(
      .N     (DEPTH),
      .IDX_W (IDX_W)
   ) u_issue_pick (
      .req   (ready_vec),
      .found (issue_found),
      .idx   (issue_idx)
   );

   rs_picker #(
      .N     (DEPTH),
      .IDX_W (IDX_W)
   ) u_free_pick (
      .req   (free_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   assign in_ready = free_found & rdy;

   always_comb begin
      entries_d = entries_q;
      busy_d    = busy_q;
      op_d      = op_q;
      pc_d      = pc_q;
      datax_d   = datax_q;
      datay_d   = datay_q;
      target_d  = target_q;

      // Incoming instruction with same-cycle wakeup applied to its operands.
      new_entry        = '0;
      new_entry.valid  = 1'b1;
      new_entry.op     = in_op;
      new_entry.pc     = in_pc;
      new_entry.tagx   = in_tagx;
      new_entry.tagy   = in_tagy;
      new_entry.datax  = in_datax;
      new_entry.datay  = in_datay;
      new_entry.target = in_target;
      if (snoop_hit(in_tagx, wb_en, wb_tag)) begin
         new_entry.tagx  = `UNLOCKED;
         new_entry.datax = wb_data;
      end
      if (snoop_hit(in_tagy, wb_en, wb_tag)) begin
         new_entry.tagy  = `UNLOCKED;
         new_entry.datay = wb_data;
      end

      if (!rdy) begin
         // Stalled: entries and payload hold, but a busy pulse must not be
         // replayed to the ALU once the stall lifts.
         busy_d = 1'b0;
      end else if (flush) begin
         // Redirect wins over snoop, issue and allocation alike.
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].valid = 1'b0;
         end
         busy_d = 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
               if (snoop_hit(entries_q[i].tagx, wb_en, wb_tag)) begin
                  entries_d[i].tagx  = `UNLOCKED;
                  entries_d[i].datax = wb_data;
               end
               if (snoop_hit(entries_q[i].tagy, wb_en, wb_tag)) begin
                  entries_d[i].tagy  = `UNLOCKED;
                  entries_d[i].datay = wb_data;
               end
            end
         end

         if (issue_found) begin
            busy_d                    = 1'b1;
            op_d                      = entries_q[issue_idx].op;
            pc_d                      = entries_q[issue_idx].pc;
            datax_d                   = entries_q[issue_idx].datax;
            datay_d                   = entries_q[issue_idx].datay;
            target_d                  = entries_q[issue_idx].target;
            entries_d[issue_idx].valid = 1'b0;
         end else begin
            busy_d = 1'b0;
         end

         // The free slot is chosen from registered state, so it can never
         // be the entry issuing this cycle.
         if (in_valid && free_found) begin
            entries_d[free_idx] = new_entry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         busy_q   <= 1'b0;
         op_q     <= `OP_NOP;
         pc_q     <= `ZERO;
         datax_q  <= `ZERO;
         datay_q  <= `ZERO;
         target_q <= '0;
      end else begin
         entries_q <= entries_d;
         busy_q    <= busy_d;
         op_q      <= op_d;
         pc_q      <= pc_d;
         datax_q   <= datax_d;
         datay_q   <= datay_d;
         target_q  <= target_d;
      end
   end

   // Only fully unlocked entries issue, so the tag outputs are constant.
   assign alu_busy_out   = busy_q & rdy;
   assign alu_op_out     = op_q;
   assign alu_pc_out     = pc_q;
   assign alu_tagx_out   = `UNLOCKED;
   assign alu_tagy_out   = `UNLOCKED;
   assign alu_tagw_out   = `UNLOCKED;
   assign alu_datax_out  = datax_q;
   assign alu_datay_out  = datay_q;
   assign alu_target_out = target_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module  : tb_alu_rs
// Purpose : Self-checking bench for alu_rs: table of single-instruction
//           dispatch vectors plus hand-written wakeup, full, flush, stall and
//           asynchronous-reset sequences. Issued payloads are checked against
//           a queue of expected issues.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs;
   import alu_rs_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rdy;
   logic       in_valid;
   `SINST_T    in_op;
   `ADDR_T     in_pc;
   `REGTAG_T   in_tagx, in_tagy;
   `WORD_T     in_datax, in_datay;
   `REGADDR_T  in_target;
   logic       in_ready;
   logic       wb_en;
   `REGTAG_T   wb_tag;
   `WORD_T     wb_data;
   logic       flush;
   logic       alu_busy_out;
   `SINST_T    alu_op_out;
   `ADDR_T     alu_pc_out;
   `REGTAG_T   alu_tagx_out, alu_tagy_out, alu_tagw_out;
   `WORD_T     alu_datax_out, alu_datay_out;
   `REGADDR_T  alu_target_out;

   alu_rs #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .in_valid       (in_valid),
      .in_op          (in_op),
      .in_pc          (in_pc),
      .in_tagx        (in_tagx),
      .in_tagy        (in_tagy),
      .in_datax       (in_datax),
      .in_datay       (in_datay),
      .in_target      (in_target),
      .in_ready       (in_ready),
      .wb_en          (wb_en),
      .wb_tag         (wb_tag),
      .wb_data        (wb_data),
      .flush          (flush),
      .alu_busy_out   (alu_busy_out),
      .alu_op_out     (alu_op_out),
      .alu_pc_out     (alu_pc_out),
      .alu_tagx_out   (alu_tagx_out),
      .alu_tagy_out   (alu_tagy_out),
      .alu_tagw_out   (alu_tagw_out),
      .alu_datax_out  (alu_datax_out),
      .alu_datay_out  (alu_datay_out),
      .alu_target_out (alu_target_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pc;
      logic [31:0] dx;
      logic [31:0] dy;
      logic [4:0]  tgt;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pc;
      logic [3:0]  tx;
      logic [3:0]  ty;
      logic [31:0] dx;
      logic [31:0] dy;
      logic [4:0]  tgt;
      logic        wbe;
      logic [3:0]  wbt;
      logic [31:0] wbd;
      logic [31:0] ex_dx;
      logic [31:0] ex_dy;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] op, input logic [31:0] pc,
                         input logic [3:0] tx, input logic [3:0] ty,
                         input logic [31:0] dx, input logic [31:0] dy,
                         input logic [4:0] tgt);
      in_valid  = 1'b1;
      in_op     = op;
      in_pc     = pc;
      in_tagx   = tx;
      in_tagy   = ty;
      in_datax  = dx;
      in_datay  = dy;
      in_target = tgt;
   endtask

   task automatic push_exp(input logic [3:0] op, input logic [31:0] pc,
                           input logic [31:0] dx, input logic [31:0] dy,
                           input logic [4:0] tgt);
      exp_t e;
      e.op  = op;
      e.pc  = pc;
      e.dx  = dx;
      e.dy  = dy;
      e.tgt = tgt;
      sb_q.push_back(e);
   endtask

   // Issue monitor: every busy cycle must match the oldest expected issue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && alu_busy_out) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: got busy=1 pc=0x%0h expected busy=0", alu_pc_out);
         end else begin
            e = sb_q.pop_front();
            if (alu_op_out !== e.op || alu_pc_out !== e.pc || alu_datax_out !== e.dx ||
                alu_datay_out !== e.dy || alu_target_out !== e.tgt ||
                alu_tagx_out !== `UNLOCKED || alu_tagy_out !== `UNLOCKED ||
                alu_tagw_out !== `UNLOCKED) begin
               n_fail++;
               $display("FAIL issue_payload: got op=%0h pc=%0h dx=%0h dy=%0h tgt=%0h tags=%0h/%0h/%0h expected op=%0h pc=%0h dx=%0h dy=%0h tgt=%0h tags=0",
                        alu_op_out, alu_pc_out, alu_datax_out, alu_datay_out, alu_target_out,
                        alu_tagx_out, alu_tagy_out, alu_tagw_out,
                        e.op, e.pc, e.dx, e.dy, e.tgt);
            end
         end
      end
   end

   initial begin
      // op, pc, tx, ty, dx, dy, tgt, wbe, wbt, wbd, ex_dx, ex_dy
      vecs[0] = '{`OP_ADD, 32'h0000_0100, 4'h0, 4'h0, 32'd5,         32'd7,         5'd1,  1'b0, 4'h0, 32'h0,         32'd5,         32'd7};
      vecs[1] = '{`OP_SUB, 32'h0000_0104, 4'h0, 4'h0, 32'hFFFF_FFFF, 32'h1,         5'd2,  1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 32'h1};
      vecs[2] = '{`OP_AND, 32'h0000_0108, 4'h0, 4'h4, 32'h0F0F_0F0F, 32'hDEAD,      5'd3,  1'b1, 4'h4, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1234_5678};
      vecs[3] = '{`OP_OR,  32'h0000_010C, 4'h6, 4'h0, 32'hBEEF,      32'h3,         5'd4,  1'b1, 4'h6, 32'h0000_AAAA, 32'h0000_AAAA, 32'h3};
      vecs[4] = '{`OP_XOR, 32'h0000_0110, 4'h0, 4'h0, 32'h11,        32'h22,        5'd5,  1'b1, 4'h5, 32'hCAFE,      32'h11,        32'h22};
      vecs[5] = '{`OP_ADD, 32'h0000_0114, 4'h0, 4'h0, 32'h33,        32'h44,        5'd6,  1'b1, 4'h0, 32'h5555_5555, 32'h33,        32'h44};
      vecs[6] = '{`OP_ADD, 32'hFFFF_FFFC, 4'h0, 4'h0, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 1'b0, 4'h0, 32'h0,         32'h8000_0000, 32'h7FFF_FFFF};

      rst_n = 1'b0; rdy = 1'b1; in_valid = 1'b0; flush = 1'b0;
      in_op = `OP_NOP; in_pc = '0; in_tagx = '0; in_tagy = '0;
      in_datax = '0; in_datay = '0; in_target = '0;
      wb_en = 1'b0; wb_tag = '0; wb_data = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_busy",   32'(alu_busy_out), 32'd0);
      chk("rst_op",     32'(alu_op_out), 32'(`OP_NOP));
      chk("rst_pc",     alu_pc_out, `ZERO);
      chk("rst_datax",  alu_datax_out, `ZERO);
      chk("rst_datay",  alu_datay_out, `ZERO);
      chk("rst_target", 32'(alu_target_out), 32'd0);
      chk("rst_tags",   32'({alu_tagx_out, alu_tagy_out, alu_tagw_out}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Table of independent dispatches: issue exactly two cycles later.
      for (int k = 0; k < 7; k++) begin
         chk("vec_in_ready", 32'(in_ready), 32'd1);
         set_in(vecs[k].op, vecs[k].pc, vecs[k].tx, vecs[k].ty, vecs[k].dx, vecs[k].dy, vecs[k].tgt);
         wb_en = vecs[k].wbe; wb_tag = vecs[k].wbt; wb_data = vecs[k].wbd;
         push_exp(vecs[k].op, vecs[k].pc, vecs[k].ex_dx, vecs[k].ex_dy, vecs[k].tgt);
         tick();
         in_valid = 1'b0; wb_en = 1'b0;
         @(negedge clk); chk("vec_busy_cycle1", 32'(alu_busy_out), 32'd0);
         @(negedge clk); chk("vec_busy_cycle2", 32'(alu_busy_out), 32'd1);
      end
      @(negedge clk); chk("vec_busy_drop", 32'(alu_busy_out), 32'd0);

      // Pending SUB woken by a broadcast three cycles after dispatch.
      set_in(`OP_SUB, 32'h0000_0200, 4'h3, 4'h0, 32'hBAD0, 32'h2, 5'd7);
      tick();
      in_valid = 1'b0;
      tick(); tick();
      wb_en = 1'b1; wb_tag = 4'h3; wb_data = 32'h10;
      push_exp(`OP_SUB, 32'h0000_0200, 32'h10, 32'h2, 5'd7);
      tick();
      wb_en = 1'b0;
      @(negedge clk); chk("wake_busy_cycle1", 32'(alu_busy_out), 32'd0);
      @(negedge clk); chk("wake_busy_cycle2", 32'(alu_busy_out), 32'd1);
      chk("wake_datax", alu_datax_out, 32'h10);

      // Fill all four entries blocked on tag 9, then try a fifth.
      for (int j = 0; j < 4; j++) begin
         set_in(`OP_ADD, 32'h0000_0300 + 32'(4 * j), 4'h9, 4'h0, 32'h0, 32'(j + 1), 5'(j + 8));
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk); chk("full_in_ready", 32'(in_ready), 32'd0);
      set_in(`OP_XOR, 32'h0000_0BAD, 4'h0, 4'h0, 32'h1, 32'h1, 5'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk); chk("full_in_ready_after_5th", 32'(in_ready), 32'd0);
      wb_en = 1'b1; wb_tag = 4'h9; wb_data = 32'h99;
      for (int j = 0; j < 4; j++) begin
         push_exp(`OP_ADD, 32'h0000_0300 + 32'(4 * j), 32'h99, 32'(j + 1), 5'(j + 8));
      end
      tick();
      wb_en = 1'b0;
      @(negedge clk);
      chk("drain_busy_c1", 32'(alu_busy_out), 32'd0);
      chk("drain_ready_c1", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("drain_busy_c2", 32'(alu_busy_out), 32'd1);
      chk("drain_ready_c2", 32'(in_ready), 32'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); chk("drain_busy_run", 32'(alu_busy_out), 32'd1);
      end
      @(negedge clk); chk("drain_busy_end", 32'(alu_busy_out), 32'd0);
      chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

      // Flush with three pending entries, one ready entry and a dispatch.
      for (int j = 0; j < 3; j++) begin
         set_in(`OP_SUB, 32'h0000_0400 + 32'(4 * j), 4'hC, 4'h0, 32'h1, 32'h1, 5'd9);
         tick();
      end
      set_in(`OP_ADD, 32'h0000_0410, 4'h0, 4'h0, 32'h2, 32'h2, 5'd9);
      tick();
      set_in(`OP_ADD, 32'h0000_0420, 4'h0, 4'h0, 32'h3, 32'h3, 5'd9);
      flush = 1'b1; wb_en = 1'b1; wb_tag = 4'hC; wb_data = 32'h77;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_busy", 32'(alu_busy_out), 32'd0);
      chk("flush_pc_held", alu_pc_out, 32'h0000_030C);
      tick();
      wb_en = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); chk("flush_quiet", 32'(alu_busy_out), 32'd0);
      end
      set_in(`OP_OR, 32'h0000_0500, 4'h0, 4'h0, 32'h5, 32'h6, 5'd10);
      push_exp(`OP_OR, 32'h0000_0500, 32'h5, 32'h6, 5'd10);
      tick();
      in_valid = 1'b0;
      @(negedge clk); chk("post_flush_busy1", 32'(alu_busy_out), 32'd0);
      @(negedge clk); chk("post_flush_busy2", 32'(alu_busy_out), 32'd1);

      // Stall: dispatch is refused while rdy is low.
      @(negedge clk);
      rdy = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      set_in(`OP_ADD, 32'h0000_0600, 4'h0, 4'h0, 32'h1, 32'h1, 5'd1);
      tick();
      in_valid = 1'b0; rdy = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); chk("stall_no_issue", 32'(alu_busy_out), 32'd0);
      end

      // Asynchronous reset while the ALU is busy.
      set_in(`OP_ADD, 32'h0000_0700, 4'h0, 4'h0, 32'h1, 32'h2, 5'd3);
      tick();
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_areset_busy", 32'(alu_busy_out), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("areset_busy",   32'(alu_busy_out), 32'd0);
      chk("areset_op",     32'(alu_op_out), 32'(`OP_NOP));
      chk("areset_pc",     alu_pc_out, `ZERO);
      chk("areset_data",   alu_datax_out | alu_datay_out, `ZERO);
      chk("areset_target", 32'(alu_target_out), 32'd0);
      chk("areset_tags",   32'({alu_tagx_out, alu_tagy_out, alu_tagw_out}), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rerst_in_ready", 32'(in_ready), 32'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); chk("rerst_quiet", 32'(alu_busy_out), 32'd0);
      end
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
